// File: rtl/wb_pkg.sv
// Shared types, default widths and the wrap-around scan helper
// for the wb_arb writeback arbiter.
package wb_pkg;

  localparam int ECAUSE_W  = 5;
  localparam int NCH_D     = 6;
  localparam int NBUS_D    = 2;
  localparam int DEPTH_D   = 2;
  localparam int ROBID_W_D = 7;
  localparam int RD_W_D    = 6;
  localparam int DATA_W_D  = 32;

  // Scan vectors are padded to this width (NCH <= 16).
  localparam int SCAN_W = 16;

  typedef struct packed {
    logic                 error;
    logic [ECAUSE_W-1:0]  ecause;
    logic [ROBID_W_D-1:0] robid;
    logic [RD_W_D-1:0]    rd;
    logic [DATA_W_D-1:0]  result;
  } wb_pkt_t;

  // First set bit of req[n-1:0] starting at 'start', stepping up
  // (or down when desc) with wrap mod n. Returns {found, index}.
  function automatic logic [4:0] scan_wrap(
    input logic [SCAN_W-1:0] req,
    input int                start,
    input int                n,
    input logic              desc
  );
    logic [4:0] r;
    int         j;
    r = '0;
    for (int k = SCAN_W - 1; k >= 0; k--) begin
      if (desc) j = (((start - k) % n) + n) % n;
      else      j = (start + k) % n;
      if (k < n && req[j]) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_if.sv
// Producer-side channel bundle and result-bus bundle of wb_arb.
// master: functional units + ROB side; slave: the arbiter.
interface wb_arb_if
  import wb_pkg::*;
#(
  parameter int NCH     = NCH_D,
  parameter int NBUS    = NBUS_D,
  parameter int ROBID_W = ROBID_W_D,
  parameter int RD_W    = RD_W_D,
  parameter int DATA_W  = DATA_W_D
);

  logic [NCH-1:0]          ch_valid;
  logic [NCH-1:0]          ch_error;
  logic [NCH*ECAUSE_W-1:0] ch_ecause;
  logic [NCH*ROBID_W-1:0]  ch_robid;
  logic [NCH*RD_W-1:0]     ch_rd;
  logic [NCH*DATA_W-1:0]   ch_result;
  logic [NCH-1:0]          ch_stall;

  logic [NBUS-1:0]          wb_valid;
  logic [NBUS-1:0]          wb_error;
  logic [NBUS*ECAUSE_W-1:0] wb_ecause;
  logic [NBUS*ROBID_W-1:0]  wb_robid;
  logic [NBUS*RD_W-1:0]     wb_rd;
  logic [NBUS*DATA_W-1:0]   wb_result;

  logic rob_flush;

  modport master (
    output ch_valid, ch_error, ch_ecause,
    output ch_robid, ch_rd, ch_result,
    output rob_flush,
    input  ch_stall,
    input  wb_valid, wb_error, wb_ecause,
    input  wb_robid, wb_rd, wb_result
  );

  modport slave (
    input  ch_valid, ch_error, ch_ecause,
    input  ch_robid, ch_rd, ch_result,
    input  rob_flush,
    output ch_stall,
    output wb_valid, wb_error, wb_ecause,
    output wb_robid, wb_rd, wb_result
  );

endinterface

// File: rtl/wb_chan_fifo.sv
// Per-channel skid FIFO of result packets.
// Ports: clk, rst, push, pop, flush, din -> full, empty, head.
module wb_chan_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = DEPTH_D,
  parameter type T     = wb_pkt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      // Single-entry FIFO keeps both pointers at 0.
      if (push) wp <= (DEPTH > 1) ? wp + 1'b1 : '0;
      if (pop)  rp <= (DEPTH > 1) ? rp + 1'b1 : '0;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: NCH FU channels -> per-channel FIFOs -> NBUS
// result buses, round-robin (fixed descending priority when
// WB_FIXED_PRIO_EN is defined). Ports: clk, rst, bus (slave).
module wb_arb
  import wb_pkg::*;
#(
  parameter int NCH     = NCH_D,
  parameter int NBUS    = NBUS_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int ROBID_W = ROBID_W_D,
  parameter int RD_W    = RD_W_D,
  parameter int DATA_W  = DATA_W_D
) (
  input logic      clk,
  input logic      rst,
  wb_arb_if.slave  bus
);

  localparam int IDX_W = $clog2(NCH);

  typedef struct packed {
    logic                error;
    logic [ECAUSE_W-1:0] ecause;
    logic [ROBID_W-1:0]  robid;
    logic [RD_W-1:0]     rd;
    logic [DATA_W-1:0]   result;
  } pkt_t;

  pkt_t           pkt_in [NCH];
  pkt_t           head   [NCH];
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign pkt_in[i] = '{
      error:  bus.ch_error[i],
      ecause: bus.ch_ecause[i*ECAUSE_W +: ECAUSE_W],
      robid:  bus.ch_robid[i*ROBID_W +: ROBID_W],
      rd:     bus.ch_rd[i*RD_W +: RD_W],
      result: bus.ch_result[i*DATA_W +: DATA_W]
    };
    assign push[i] = bus.ch_valid[i] & ~full[i];

    wb_chan_fifo #(
      .DEPTH (DEPTH),
      .T     (pkt_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (bus.rob_flush),
      .din   (pkt_in[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Stall depends on registered occupancy only.
  assign bus.ch_stall = full;

  logic [SCAN_W-1:0] cand;
  logic [SCAN_W-1:0] pop_w;
  logic [4:0]        hit;
  int                start;
  logic [NBUS-1:0]   gnt_v;
  logic [IDX_W-1:0]  gnt_idx [NBUS];
  logic [IDX_W-1:0]  last;

`ifdef WB_FIXED_PRIO_EN
  localparam logic DESC = 1'b1;
`else
  localparam logic DESC = 1'b0;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_nxt;

  always_comb begin
    rr_nxt = rr_ptr;
    if (|gnt_v) begin
      rr_nxt = (int'(last) == NCH - 1) ? '0 : last + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rr_ptr <= '0;
    else if (!bus.rob_flush) rr_ptr <= rr_nxt;
  end
`endif

  // Each bus rescans from the same start with earlier winners
  // removed, which yields the next candidate in scan order.
  always_comb begin
    cand          = '0;
    cand[NCH-1:0] = ~empty;
    pop_w         = '0;
    gnt_v         = '0;
    last          = '0;
    hit           = '0;
    for (int b = 0; b < NBUS; b++) gnt_idx[b] = '0;
`ifdef WB_FIXED_PRIO_EN
    start = NCH - 1;
`else
    start = int'(rr_ptr);
`endif
    for (int b = 0; b < NBUS; b++) begin
      hit = scan_wrap(cand, start, NCH, DESC);
      if (hit[4]) begin
        gnt_v[b]        = 1'b1;
        gnt_idx[b]      = IDX_W'(hit[3:0]);
        cand[hit[3:0]]  = 1'b0;
        pop_w[hit[3:0]] = 1'b1;
        last            = IDX_W'(hit[3:0]);
      end
    end
  end

  assign pop = pop_w[NCH-1:0];

  logic [NBUS-1:0]          err_o;
  logic [NBUS*ECAUSE_W-1:0] ec_o;
  logic [NBUS*ROBID_W-1:0]  rob_o;
  logic [NBUS*RD_W-1:0]     rd_o;
  logic [NBUS*DATA_W-1:0]   res_o;
  pkt_t                     sel;

  always_comb begin
    err_o = '0;
    ec_o  = '0;
    rob_o = '0;
    rd_o  = '0;
    res_o = '0;
    sel   = '0;
    for (int b = 0; b < NBUS; b++) begin
      if (gnt_v[b]) begin
        sel                             = head[gnt_idx[b]];
        err_o[b]                        = sel.error;
        ec_o[b*ECAUSE_W +: ECAUSE_W]    = sel.ecause;
        rob_o[b*ROBID_W +: ROBID_W]     = sel.robid;
        rd_o[b*RD_W +: RD_W]            = sel.rd;
        res_o[b*DATA_W +: DATA_W]       = sel.result;
      end
    end
  end

  assign bus.wb_valid  = gnt_v;
  assign bus.wb_error  = err_o;
  assign bus.wb_ecause = ec_o;
  assign bus.wb_robid  = rob_o;
  assign bus.wb_rd     = rd_o;
  assign bus.wb_result = res_o;

endmodule

// File: tb/tb_wb_arb.sv
// Randomized self-checking bench for wb_arb against a queue-based
// reference model of the arbitration rules.
module tb_wb_arb;

  localparam int NCH   = 6;
  localparam int NBUS  = 2;
  localparam int DEPTH = 2;
  localparam int RW    = 7;
  localparam int DW    = 6;
  localparam int XW    = 32;

  typedef logic [50:0] pay_t;

  logic clk;
  logic rst;

  wb_arb_if #(
    .NCH(NCH), .NBUS(NBUS), .ROBID_W(RW), .RD_W(DW), .DATA_W(XW)
  ) bus ();

  wb_arb #(
    .NCH(NCH), .NBUS(NBUS), .DEPTH(DEPTH),
    .ROBID_W(RW), .RD_W(DW), .DATA_W(XW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pay_t           q [NCH][$];
  int             rr;
  pay_t           pay [NCH];
  logic [NCH-1:0] vin;
  logic           flin;
  logic [NCH-1:0] last_push;
  logic [NBUS-1:0] obs_valid;
  logic [RW-1:0]   obs_rob [NBUS];
  int              outq [$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t mk(input logic [6:0] rob, input logic [31:0] r);
    return {1'b0, 5'd0, rob, r[5:0], r};
  endfunction

  task automatic drive();
    bus.ch_valid  = vin;
    bus.rob_flush = flin;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_error[i]          = pay[i][50];
      bus.ch_ecause[i*5 +: 5]  = pay[i][49:45];
      bus.ch_robid[i*RW +: RW] = pay[i][44:38];
      bus.ch_rd[i*DW +: DW]    = pay[i][37:32];
      bus.ch_result[i*XW +: XW] = pay[i][31:0];
    end
  endtask

  // One cycle: drive at negedge, compare, model update at posedge.
  task automatic step();
    int             g [NBUS];
    int             n;
    int             idx;
    logic [NCH-1:0] stl;
    logic [NBUS-1:0] ev;
    pay_t           got;
    drive();
    #1;
    n = 0;
    for (int k = 0; k < NCH; k++) begin
`ifdef WB_FIXED_PRIO_EN
      idx = NCH - 1 - k;
`else
      idx = (rr + k) % NCH;
`endif
      if (q[idx].size() > 0 && n < NBUS) begin
        g[n] = idx;
        n++;
      end
    end
    for (int i = 0; i < NCH; i++) stl[i] = (q[i].size() == DEPTH);
    ev = '0;
    for (int b = 0; b < n; b++) ev[b] = 1'b1;
    check("stall", 64'(bus.ch_stall), 64'(stl));
    check("valid", 64'(bus.wb_valid), 64'(ev));
    obs_valid = bus.wb_valid;
    for (int b = 0; b < NBUS; b++) begin
      obs_rob[b] = bus.wb_robid[b*RW +: RW];
      if (bus.wb_valid[b]) outq.push_back(int'(obs_rob[b]));
    end
    for (int b = 0; b < n; b++) begin
      got = {bus.wb_error[b], bus.wb_ecause[b*5 +: 5],
             bus.wb_robid[b*RW +: RW], bus.wb_rd[b*DW +: DW],
             bus.wb_result[b*XW +: XW]};
      check("payload", 64'(got), 64'(q[g[b]][0]));
    end
    @(posedge clk);
    last_push = '0;
    if (flin) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
    end else begin
      for (int b = 0; b < n; b++) void'(q[g[b]].pop_front());
      for (int i = 0; i < NCH; i++) begin
        if (vin[i] && !stl[i]) begin
          q[i].push_back(pay[i]);
          last_push[i] = 1'b1;
        end
      end
      if (n > 0) rr = (g[n-1] + 1) % NCH;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) q[i].delete();
    rr = 0;
  endtask

  int   bp_n;
  logic bp_stall;
  int   hi [$];

  initial begin
    rst  = 1'b1;
    vin  = '0;
    flin = 1'b0;
    for (int i = 0; i < NCH; i++) pay[i] = '0;
    drive();
    model_reset();
    @(negedge clk);
    check("rst_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_stall", 64'(bus.ch_stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single channel
    vin    = 6'b000100;
    pay[2] = mk(7'h15, 32'hDEADBEEF);
    step();
    vin = '0;
    step();
    check("single_v", 64'(obs_valid), 64'h1);
    check("single_rob", 64'(obs_rob[0]), 64'h15);
    step();
    check("single_empty", 64'(obs_valid), 64'h0);

    // reset with three entries queued
    vin    = 6'b000111;
    pay[0] = mk(7'h01, 32'h11);
    pay[1] = mk(7'h02, 32'h22);
    pay[2] = mk(7'h03, 32'h33);
    step();
    vin = '0;
    drive();
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.wb_valid), 64'd0);
    check("midrst_stall", 64'(bus.ch_stall), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst", 64'(obs_valid), 64'h0);

    // contention from rr_ptr = 0
    vin    = 6'b001011;
    pay[0] = mk(7'h20, 32'hA0);
    pay[1] = mk(7'h21, 32'hA1);
    pay[3] = mk(7'h23, 32'hA3);
    step();
    vin = '0;
    step();
    check("cont1_v", 64'(obs_valid), 64'h3);
    check("cont1_b0", 64'(obs_rob[0]), 64'h20);
    check("cont1_b1", 64'(obs_rob[1]), 64'h21);
    step();
    check("cont2_v", 64'(obs_valid), 64'h1);
    check("cont2_b0", 64'(obs_rob[0]), 64'h23);

    // backpressure on channel 4
    outq.delete();
    bp_n     = 0;
    bp_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < 4; i++) pay[i] = mk(7'($urandom_range(0, 63)), $urandom);
      pay[4] = mk(7'(64 + bp_n), 32'h4000 + 32'(bp_n));
      vin    = {1'b0, (bp_n < 4), 4'hF};
      step();
      if (bus.ch_stall[4]) bp_stall = 1'b1;
      if (last_push[4]) bp_n++;
    end
    vin = '0;
    for (int c = 0; c < 12; c++) step();
    check("bp_stall", 64'(bp_stall), 64'h1);
    hi.delete();
    foreach (outq[j]) if (outq[j] >= 64) hi.push_back(outq[j]);
    check("bp_count", 64'(hi.size()), 64'd4);
    foreach (hi[j]) check("bp_order", 64'(hi[j]), 64'(64 + j));

    // flush with a concurrent push
    vin = '1;
    for (int i = 0; i < NCH; i++) pay[i] = mk(7'(i), 32'(i));
    step();
    step();
    vin  = 6'b000010;
    flin = 1'b1;
    step();
    flin = 1'b0;
    vin  = '0;
    step();
    check("flush_empty", 64'(obs_valid), 64'h0);
    vin = '1;
    step();
    vin = '0;
    step();
    step();

    // random traffic
    for (int c = 0; c < 500; c++) begin
      vin  = NCH'($urandom);
      flin = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NCH; i++) pay[i] = 51'({$urandom, $urandom});
      step();
    end
    vin  = '0;
    flin = 1'b0;
    for (int c = 0; c < 8; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
Name: wb_arb

Overview:
- Parametrised writeback / common-data-bus arbiter.
- Collects results from NCH functional-unit channels (ALUs, LSQ, CSR …) into per-channel skid FIFOs.
- Grants up to NBUS distinct channels per cycle onto NBUS result buses, round-robin.
- Successor to the single-bus, single-register, fixed-priority writeback stage; sits between the FUs and ROB/RS wakeup.

Parameters:
- NCH, 6, number of producer channels (2..16).
- NBUS, 2, number of result buses driven per cycle (1..NCH).
- DEPTH, 2, entries per channel FIFO (power of two, >=1).
- ROBID_W, 7, ROB id width.
- RD_W, 6, destination register tag width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ch_valid  in  NCH  per-channel result valid.
- ch_error  in  NCH  per-channel exception flag.
- ch_ecause  in  NCH*5  exception cause; channel i at [5i+4:5i].
- ch_robid  in  NCH*ROBID_W  ROB id per channel.
- ch_rd  in  NCH*RD_W  destination tag per channel.
- ch_result  in  NCH*DATA_W  result data per channel.
- ch_stall  out  NCH  channel i FIFO full; producer must hold its payload.
- wb_valid  out  NBUS  bus b carries a result.
- wb_error  out  NBUS  exception flag per bus.
- wb_ecause  out  NBUS*5  cause per bus.
- wb_robid  out  NBUS*ROBID_W  ROB id per bus.
- wb_rd  out  NBUS*RD_W  destination tag per bus.
- wb_result  out  NBUS*DATA_W  result per bus.
- rob_flush  in  1  pipeline flush.

Behaviour:
- Reset (async): all FIFO counts/pointers 0, rr_ptr=0.
  - Consequently ch_stall=0 and wb_valid=0 immediately, during reset and on the first cycle after it.
- Enqueue: at posedge, channel i pushes when ch_valid[i] & ~ch_stall[i]. Valid while stalled is ignored; the producer holds its payload.
- ch_stall[i] = (count_i == DEPTH), derived from registered state only; no combinational path from any input.
  - A full FIFO that is popped this cycle still reports stall (conservative).
- Output timing:
  - Bus outputs are combinational from FIFO heads and rr_ptr.
  - A result pushed at edge N into an empty FIFO appears on a bus in cycle N+1 at the earliest (1-cycle latency).
- Arbitration:
  - Candidates = channels with non-empty FIFO.
  - Bus 0 takes the first candidate at index >= rr_ptr, scanning upward with wrap mod NCH; bus 1 takes the next candidate after that; and so on.
  - A channel gets at most one bus per cycle.
  - Unused buses have wb_valid=0; their payload is don't-care but must be X-free (drive 0).
- Pop: every granted channel pops its head at the posedge ending the grant cycle. Push and pop on the same channel in the same cycle leaves count unchanged.
- rr_ptr update: becomes (last granted index + 1) mod NCH; unchanged when there are no grants.
- Bus fill order: buses fill in index order; wb_valid is always a contiguous run from bit 0.
- rob_flush:
  - At posedge, all FIFOs are emptied and inputs presented that cycle are discarded; rr_ptr is unchanged.
  - Grants shown during the flush cycle are still driven; the ROB ignores them.
- Error entries are arbitrated identically to normal results.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro WB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed; the scan starts at the highest index and descends, so channel NCH-1 has absolute priority (legacy ordering; LSQ wired to the top index).
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package wb_pkg:
  - ECAUSE_W=5 and default widths.
  - Struct wb_pkt_t {error, ecause, robid, rd, result}.
  - Function for wrap-around first-set scan.
- Sub-module wb_chan_fifo (one per channel, generate loop): DEPTH-entry FIFO of wb_pkt_t with push, pop, flush, full, empty and head outputs.
- The arbiter and output muxing stay in wb_arb.

Test Plan:
- Reset mid-traffic: assert rst with 3 entries queued -> wb_valid=0 and ch_stall=0 combinationally while rst is high; the first cycle after release shows no stale results.
- Single channel: ch_valid[2]=1, robid=0x15, result=0xDEADBEEF for one cycle -> next cycle wb_valid=2'b01 on bus 0 with the same payload; after that, empty.
- Contention, NBUS=2, round-robin: channels 0, 1, 3 each push one entry at the same edge, rr_ptr=0 -> cycle 1 grants ch0 on bus 0 and ch1 on bus 1, rr_ptr=2; cycle 2 grants ch3 on bus 0 only, wb_valid=2'b01.
- Backpressure, DEPTH=2: hold ch_valid[4] for 4 cycles while channels 0..3 keep the buses busy -> ch_stall[4]=1 after 2 pushes; exactly 4 distinct robids exit, in order, no loss or duplication.
- Flush: 2 entries queued in ch1, rob_flush=1 together with ch_valid[1] -> next cycle all FIFOs empty, wb_valid=0, rr_ptr preserved.
- WB_FIXED_PRIO_EN, NBUS=1: channels 5 and 0 valid continuously -> ch5 granted every cycle, ch0 starves with ch_stall[0]=1 once full.
